// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller for the combinational 32-bit ALU: decode, hold, capture, respond.
// Optional macro ALU_ILLEGAL_CHK_EN enables reporting of illegal encodings on rsp_illegal.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned OTHER_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal
);

  localparam logic [3:0] SelAnd = 4'b0000;
  localparam logic [3:0] SelOr  = 4'b0001;
  localparam logic [3:0] SelAdd = 4'b0010;
  localparam logic [3:0] SelMul = 4'b0100;
  localparam logic [3:0] SelSub = 4'b0110;

  localparam logic [3:0] MulCnt   = 4'(MUL_LAT - 1);
  localparam logic [3:0] OtherCnt = 4'(OTHER_LAT - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_sel;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        r_rsp_zero;

  logic [3:0]  w_sel;
  logic        w_is_mul;

  // Unrecognised encodings fall back to add
  always_comb begin
    w_sel    = SelAdd;
    w_is_mul = 1'b0;
    case (alu_op)
      2'b00: w_sel = SelAdd;
      2'b01: w_sel = SelSub;
      2'b10: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
          w_sel    = SelMul;
          w_is_mul = 1'b1;
        end else if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          w_sel = SelAdd;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          w_sel = SelSub;
        end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
          w_sel = SelAnd;
        end else if (funct3 == 3'b110 && funct7 == 7'b0000000) begin
          w_sel = SelOr;
        end else begin
          w_sel = SelAdd;
        end
      end
      default: w_sel = SelAdd;
    endcase
  end

`ifdef ALU_ILLEGAL_CHK_EN
  logic w_illegal;
  logic r_illegal;
  logic r_rsp_illegal;

  always_comb begin
    w_illegal = 1'b0;
    if (alu_op == 2'b11) begin
      w_illegal = 1'b1;
    end else if (alu_op == 2'b10) begin
      w_illegal = !((funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0000001 ||
                                          funct7 == 7'b0100000)) ||
                    ((funct3 == 3'b111 || funct3 == 3'b110) && funct7 == 7'b0000000));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal     <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else if (r_state == StIdle && req_valid) begin
      r_illegal <= w_illegal;
    end else if (r_state == StExec && r_cnt == 4'd0) begin
      r_rsp_illegal <= r_illegal;
    end
  end

  assign rsp_illegal = r_rsp_illegal;
`else
  assign rsp_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_alu_sel    <= SelAdd;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_alu_a     <= op_a;
            r_alu_b     <= op_b;
            r_alu_sel   <= w_sel;
            r_cnt       <= w_is_mul ? MulCnt : OtherCnt;
            r_req_ready <= 1'b0;
            r_state     <= StExec;
          end
        end
        StExec: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_result <= alu_out;
            r_rsp_zero   <= alu_zero;
            r_rsp_valid  <= 1'b1;
            r_state      <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU; MUL_LAT=3, OTHER_LAT=1.
module tb_alu_issue_ctrl;

  localparam int unsigned MulLat   = 3;
  localparam int unsigned OtherLat = 1;
`ifdef ALU_ILLEGAL_CHK_EN
  localparam logic IllOn = 1'b1;
`else
  localparam logic IllOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [6:0]  funct7 = 7'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .MUL_LAT  (MulLat),
    .OTHER_LAT(OtherLat)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7     (funct7),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_illegal(rsp_illegal)
  );

  // Behavioural combinational ALU
  always_comb begin
    alu_out = 32'd0;
    case (alu_sel)
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0100: alu_out = {16'd0, alu_a[15:0]} * {16'd0, alu_b[15:0]};
      default: alu_out = 32'hBAD0_BAD0;
    endcase
  end
  assign alu_zero = ((alu_a - alu_b) == 32'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got result %h with no expected entry at %0t",
                 rsp_result, $time);
      end else begin
        check("rsp_result", rsp_result, sb_q[0].res);
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, sb_q[0].zero});
        check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, sb_q[0].ill});
        if (rsp_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                       input logic [31:0] res, input logic zero, input logic ill,
                       input int lat, input int hold);
    exp_t e;
    int   cyc;
    bit   got;
    e.res  = res;
    e.zero = zero;
    e.ill  = ill & IllOn;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    alu_op    = op;
    funct3    = f3;
    funct7    = f7;
    op_a      = a;
    op_b      = b;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept", {31'd0, got}, 32'd1);
    if (!got) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op_a      = ~a;
    op_b      = ~b;
    alu_op    = ~op;
    funct3    = ~f3;
    check("alu_sel", {28'd0, alu_sel}, {28'd0, sel});
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("req_ready_exec", {31'd0, req_ready}, 32'd0);
    cyc = 1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      check("exec_stable_a", alu_a, a);
      check("exec_stable_sel", {28'd0, alu_sel}, {28'd0, sel});
    end
    check("latency", 32'(cyc), 32'(1 + lat));
    if (!got) return;
    if (hold > 0) begin
      // Competing request while the response is stalled must not be taken
      req_valid = 1'b1;
      alu_op    = 2'b00;
      op_a      = 32'hDEAD_0000;
      op_b      = 32'h0000_BEEF;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_alu_a", alu_a, a);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_sel", {28'd0, alu_sel}, 32'h2);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    check("rst_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);

    //     op     f3      f7          a             b             sel      res          z     ill
    issue(2'b10, 3'b000, 7'b0000000, 32'd5,        32'd7,        4'b0010, 32'd12,      1'b0, 1'b0, OtherLat, 0);
    issue(2'b01, 3'b000, 7'b0000000, 32'h1234,     32'h1234,     4'b0110, 32'd0,       1'b1, 1'b0, OtherLat, 0);
    issue(2'b10, 3'b000, 7'b0000001, 32'h0003,     32'hFFFF,     4'b0100, 32'h2FFFD,   1'b0, 1'b0, MulLat,   0);
    issue(2'b10, 3'b111, 7'b0000000, 32'hF0F0,     32'h0FF0,     4'b0000, 32'h00F0,    1'b0, 1'b0, OtherLat, 5);
    issue(2'b10, 3'b110, 7'b0000000, 32'h0F00,     32'h00F0,     4'b0001, 32'h0FF0,    1'b0, 1'b0, OtherLat, 0);
    issue(2'b10, 3'b000, 7'b0100000, 32'd10,       32'd3,        4'b0110, 32'd7,       1'b0, 1'b0, OtherLat, 0);
    issue(2'b00, 3'b111, 7'b0000001, 32'h100,      32'h20,       4'b0010, 32'h120,     1'b0, 1'b0, OtherLat, 0);
    issue(2'b11, 3'b000, 7'b0000000, 32'd1,        32'd1,        4'b0010, 32'd2,       1'b1, 1'b1, OtherLat, 0);
    issue(2'b10, 3'b001, 7'b0000000, 32'd4,        32'd4,        4'b0010, 32'd8,       1'b1, 1'b1, OtherLat, 0);
    issue(2'b10, 3'b111, 7'b0000001, 32'd2,        32'd3,        4'b0010, 32'd5,       1'b0, 1'b1, OtherLat, 0);

    // Abort a multiply mid-execution with reset
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    alu_op    = 2'b10;
    funct3    = 3'b000;
    funct7    = 7'b0000001;
    op_a      = 32'd7;
    op_b      = 32'd9;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_accept", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_sel", {28'd0, alu_sel}, 32'h4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_alu_sel", {28'd0, alu_sel}, 32'h2);
    check("abort_alu_a", alu_a, 32'd0);
    repeat (6) @(posedge clk);

    issue(2'b00, 3'b000, 7'b0000000, 32'hFFFF_FFFF, 32'd1,       4'b0010, 32'd0,       1'b0, 1'b0, OtherLat, 0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential initiator that drives the core's combinational 32-bit ALU.
- Accepts one operation per request handshake and decodes the ALU operation class plus funct fields into the 4-bit ALU select.
- Presents registered operands and select to the ALU, waits a configurable number of cycles (the multiply path is multicycle), then captures the result and zero flag.
- Returns the captured values to the pipeline over a valid/ready response handshake.

Parameters:
- MUL_LAT, 2, cycles the ALU inputs are held stable for a multiply before capture; legal range 1..15.
- OTHER_LAT, 1, cycles held for add/sub/and/or before capture; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- alu_op  input  2  operation class: 00 load/store, 01 branch, 10 R-type, 11 reserved.
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7.
- op_a  input  32  operand A.
- op_b  input  32  operand B.
- alu_a  output  32  registered operand A to the ALU.
- alu_b  output  32  registered operand B to the ALU.
- alu_sel  output  4  registered ALU select.
- alu_out  input  32  ALU result.
- alu_zero  input  1  ALU zero flag. It is high when A-B==0, independent of the select.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  32  captured result.
- rsp_zero  output  1  captured zero flag.
- rsp_illegal  output  1  illegal-encoding flag (see Optional Feature).

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, all state and outputs are set as follows.
  - State: IDLE; counter: 0.
  - alu_a=0, alu_b=0, alu_sel=4'b0010.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_illegal=0.
- Reset during EXEC or RESP aborts the operation; no response is produced.
- Select decode:
  - alu_op=00 -> 0010 (add).
  - alu_op=01 -> 0110 (sub).
  - alu_op=10 decodes on funct fields:
    - funct7=0000001, funct3=000 -> 0100 (mul, 16x16 of the low operand halves).
    - funct7=0000000, funct3=000 -> 0010 (add).
    - funct7=0100000, funct3=000 -> 0110 (sub).
    - funct3=111, funct7=0 -> 0000 (and).
    - funct3=110, funct7=0 -> 0001 (or).
  - Any other encoding, including alu_op=11, -> 0010 (add) and is marked illegal.
- State machine:
  - IDLE:
    - req_ready=1.
    - When req_valid=1, register op_a, op_b and the decoded select onto alu_a, alu_b, alu_sel.
    - Load the counter with (MUL_LAT-1) for mul or (OTHER_LAT-1) otherwise.
    - Go to EXEC.
  - EXEC:
    - req_ready=0; alu_* outputs held stable.
    - While counter is not 0, decrement it.
    - When counter is 0: rsp_result<=alu_out, rsp_zero<=alu_zero, rsp_illegal<=latched illegal bit; go to RESP.
  - RESP:
    - req_ready=0; rsp_valid=1.
    - rsp_* outputs held stable until rsp_ready=1.
    - On the handshake edge, rsp_valid<=0 and go to IDLE.
- Latency from the request-accept edge to rsp_valid high: 1+OTHER_LAT cycles for non-mul, 1+MUL_LAT cycles for mul.
- Throughput: no new request is accepted in the cycle a response handshakes. The next acceptance is in the following IDLE cycle.
- rsp_ready asserted outside RESP is ignored.
- req_valid while req_ready=0 is ignored. The requester holds the request until it is accepted.
- alu_a, alu_b and alu_sel keep their last values in IDLE (no toggling while idle).

Optional Feature:
- Macro: ALU_ILLEGAL_CHK_EN.
- Defined: rsp_illegal reports the decode's illegal bit, captured with the result. The operation still executes as add.
- Undefined: illegal-encoding logic is omitted, rsp_illegal is tied to 0, and illegal encodings silently execute as add.

Test Plan:
- Reset, then R-type add: op_a=5, op_b=7, alu_op=10, funct3=000, funct7=0 -> alu_sel=0010; rsp_valid rises 2 cycles after accept; rsp_result=12, rsp_zero=0.
- Branch compare: alu_op=01, op_a=op_b=0x1234 -> alu_sel=0110, rsp_result=0, rsp_zero=1.
- Multiply with MUL_LAT=3: funct7=0000001, op_a=0x0003, op_b=0xFFFF -> alu_sel=0100; rsp_valid rises 4 cycles after accept; rsp_result equals the ALU product; alu inputs stable throughout EXEC.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with an and op (0xF0F0 & 0x0FF0) -> rsp_valid=1 and rsp_result=0x00F0 stable; req_ready=0 throughout; a request driven meanwhile is not accepted until IDLE.
- Reset mid-EXEC during a mul -> next cycle: state IDLE, rsp_valid=0, alu_sel=0010, req_ready=1; no response emitted.
- Illegal encoding alu_op=11 with ALU_ILLEGAL_CHK_EN defined, op_a=1, op_b=1 -> rsp_result=2, rsp_illegal=1. With the macro undefined -> rsp_result=2, rsp_illegal=0.
